// File: rtl/fft_readout_sched_if.sv
// Downstream bin stream of fft_readout_sched.
//   out_data  : bin value {real, imag}
//   out_ch    : channel index of out_data
//   out_bin   : bin index of out_data
//   out_last  : final bin of the final channel
//   out_valid : head of the output buffer is valid
//   out_ready : consumer accepts (transfer when valid & ready on clk edge)
// master = scheduler side, slave = consumer side.
interface fft_readout_sched_if #(
  parameter int DW = 28,
  parameter int AW = 10
);
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic [AW-1:0] out_bin;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data, out_ch, out_bin, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_ch, out_bin, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/fft_readout_sched.sv
// Frame readout sequencer for NCH FFT channel wrappers.
// On start: pulses go to rearm the wrappers, waits for every ch_done (with a
// timeout), then reads all bins channel-major through a shared RAM address
// and streams them out via a 2-entry buffer with valid/ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle frame request (honoured only when idle)
//   ch_done      : per-channel "result complete" level
//   go           : one-cycle rearm pulse to the wrappers
//   rd_addr_fft  : shared read address (bin) to all channel RAMs
//   ram_q        : concatenated RAM outputs, 1-cycle read latency
//   busy         : not idle
//   timeout_err  : sticky, cleared by reset or an accepted start
//   out_if       : downstream bin stream (master side)
module fft_readout_sched #(
  parameter int NCH     = 4,
  parameter int NPTS    = 1024,
  parameter int DW      = 28,
  parameter int TIMEOUT = 65535,
  localparam int AW     = $clog2(NPTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NCH-1:0]    ch_done,
  output logic              go,
  output logic [AW-1:0]     rd_addr_fft,
  input  logic [NCH*DW-1:0] ram_q,
  output logic              busy,
  output logic              timeout_err,
  fft_readout_sched_if.master out_if
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT);
  localparam logic [AW-1:0] LAST_BIN = AW'(NPTS - 1);
  localparam logic [1:0]    LAST_CH  = 2'(NCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic [AW-1:0] bin;
    logic          last;
  } entry_t;

  state_t        state_q, state_d;
  logic [1:0]    arm_cnt_q, arm_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          go_q, go_d;
  logic          err_q, err_d;
  logic [1:0]    rd_ch_q, rd_ch_d;
  logic [AW-1:0] rd_bin_q, rd_bin_d;
  logic          infl_q, infl_d;
  logic [1:0]    infl_ch_q, infl_ch_d;
  logic [AW-1:0] infl_bin_q, infl_bin_d;
  logic          infl_last_q, infl_last_d;
  entry_t        fifo_q [2];
  entry_t        fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;

  logic          pop;
  logic          issue;
  logic [1:0]    occ_after_pop;
  entry_t        push_entry;
  entry_t        head;

  // Output buffer. Occupancy is taken after this cycle's pop so that a
  // pop and an issue can overlap, which is what sustains 1 bin/cycle
  // while never letting buffer + in-flight exceed two entries.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop           = (fifo_cnt_q != 2'd0) && out_if.out_ready;
    occ_after_pop = fifo_cnt_q - 2'(pop) + 2'(infl_q);
    push_entry.data = ram_q[infl_ch_q*DW +: DW];
    push_entry.ch   = infl_ch_q;
    push_entry.bin  = infl_bin_q;
    push_entry.last = infl_last_q;
    if (infl_q) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + 2'(infl_q) - 2'(pop);
  end

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    go_d        = 1'b0;
    err_d       = err_q;
    rd_ch_d     = rd_ch_q;
    rd_bin_d    = rd_bin_q;
    infl_d      = 1'b0;
    infl_ch_d   = infl_ch_q;
    infl_bin_d  = infl_bin_q;
    infl_last_d = infl_last_q;
    issue       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ARM;
          arm_cnt_d = '0;
          go_d      = 1'b1;
          err_d     = 1'b0;
        end
      end
      S_ARM: begin
        // Four cycles so the wrappers' 2-FF go synchronizer has settled
        // before ch_done is trusted.
        if (arm_cnt_q == 2'd3) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        if (&ch_done) begin
          state_d  = S_READ;
          rd_ch_d  = '0;
          rd_bin_d = '0;
        end else if (wait_cnt_d == TO_VAL) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        issue = (occ_after_pop < 2'd2);
        if (issue) begin
          infl_d      = 1'b1;
          infl_ch_d   = rd_ch_q;
          infl_bin_d  = rd_bin_q;
          infl_last_d = (rd_ch_q == LAST_CH) && (rd_bin_q == LAST_BIN);
          if (rd_bin_q == LAST_BIN) begin
            rd_bin_d = '0;
            if (rd_ch_q == LAST_CH) begin
              rd_ch_d = '0;
              state_d = S_DRAIN;
            end else begin
              rd_ch_d = rd_ch_q + 2'd1;
            end
          end else begin
            rd_bin_d = rd_bin_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((fifo_cnt_q == 2'd0) && !infl_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      arm_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      go_q        <= 1'b0;
      err_q       <= 1'b0;
      rd_ch_q     <= '0;
      rd_bin_q    <= '0;
      infl_q      <= 1'b0;
      infl_ch_q   <= '0;
      infl_bin_q  <= '0;
      infl_last_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      go_q        <= go_d;
      err_q       <= err_d;
      rd_ch_q     <= rd_ch_d;
      rd_bin_q    <= rd_bin_d;
      infl_q      <= infl_d;
      infl_ch_q   <= infl_ch_d;
      infl_bin_q  <= infl_bin_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign head             = fifo_q[rd_ptr_q];
  assign go               = go_q;
  assign busy             = (state_q != S_IDLE);
  assign timeout_err      = err_q;
  assign rd_addr_fft      = rd_bin_q;
  assign out_if.out_valid = (fifo_cnt_q != 2'd0);
  assign out_if.out_data  = head.data;
  assign out_if.out_ch    = head.ch;
  assign out_if.out_bin   = head.bin;
  assign out_if.out_last  = head.last && (fifo_cnt_q != 2'd0);

endmodule

// File: tb/tb_fft_readout_sched.sv
`timescale 1ns/1ps
module tb_fft_readout_sched;
  localparam int NCH   = 4;
  localparam int NPTS  = 1024;
  localparam int DW    = 28;
  localparam int AW    = 10;
  localparam int TOUT  = 100;
  localparam int FRAME = NCH * NPTS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic [AW-1:0] bin;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NCH-1:0]    ch_done = '0;
  logic              go;
  logic [AW-1:0]     rd_addr_fft;
  logic [NCH*DW-1:0] ram_q;
  logic              busy;
  logic              timeout_err;

  fft_readout_sched_if #(.DW(DW), .AW(AW)) out_if ();

  fft_readout_sched #(.NCH(NCH), .NPTS(NPTS), .DW(DW), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ch_done     (ch_done),
    .go          (go),
    .rd_addr_fft (rd_addr_fft),
    .ram_q       (ram_q),
    .busy        (busy),
    .timeout_err (timeout_err),
    .out_if      (out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int xfer_cnt = 0;
  int go_cnt = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  int ready_mode = 0;
  logic last_seen = 1'b0;
  logic [31:0] seed = 32'h0;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Contents of channel ch, bin b in the current frame's FFT RAMs.
  function automatic logic [DW-1:0] ram_val(input logic [31:0] s, input int ch, input int b);
    logic [31:0] h;
    h = s ^ (32'(ch) * 32'h9E3779B1) ^ (32'(b) * 32'h85EBCA6B);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    return h[DW-1:0];
  endfunction

  // Synchronous-read RAMs of all channels, one cycle latency.
  always @(posedge clk)
    for (int k = 0; k < NCH; k++) ram_q[k*DW +: DW] <= ram_val(seed, k, int'(rd_addr_fft));

  always @(posedge clk) cyc++;

  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expected bins on each transfer, checks payload stability
  // while stalled, counts go pulses.
  logic [40:0] held = '0;
  logic stall_pending = 1'b0;
  always @(negedge clk) begin : mon
    logic [40:0] cur;
    exp_t e;
    cur = {out_if.out_data, out_if.out_ch, out_if.out_bin, out_if.out_last};
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending)
        check("stall_hold", 64'({1'b1, out_if.out_valid, cur}), 64'({1'b1, 1'b1, held}));
      if (out_if.out_valid && out_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected actual=ch%0d/bin%0d required=no_transfer",
                   out_if.out_ch, out_if.out_bin);
        end else begin
          e = exp_q.pop_front();
          check("xfer", 64'(cur), 64'(e));
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
        if (out_if.out_last) last_seen = 1'b1;
      end
      stall_pending = out_if.out_valid && !out_if.out_ready;
      held = cur;
      if (go) go_cnt++;
    end
  end

  task automatic new_frame(input bit expect_data);
    seed = $urandom;
    xfer_cnt = 0;
    go_cnt = 0;
    last_seen = 1'b0;
    if (expect_data)
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NPTS; b++)
          exp_q.push_back('{ram_val(seed, c, b), 2'(c), AW'(b), (c == NCH-1) && (b == NPTS-1)});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_xfers(input string name, input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(xfer_cnt >= target), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'((!busy) && (exp_q.size() == 0)), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_go"},    64'(go), 64'(0));
    check({tag, "_busy"},  64'(busy), 64'(0));
    check({tag, "_err"},   64'(timeout_err), 64'(0));
    check({tag, "_valid"}, 64'(out_if.out_valid), 64'(0));
    check({tag, "_last"},  64'(out_if.out_last), 64'(0));
    check({tag, "_addr"},  64'(rd_addr_fft), 64'(0));
    check({tag, "_data"},  64'(out_if.out_data), 64'(0));
    check({tag, "_ch"},    64'(out_if.out_ch), 64'(0));
    check({tag, "_bin"},   64'(out_if.out_bin), 64'(0));
  endtask

  initial begin
    int n;
    // Reset values
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full frame, consumer always ready, ch_done from cycle 5
    new_frame(1'b1);
    ready_mode = 0;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 ch_done = '1;
    n = 0;
    while (!last_seen && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("last_seen", 64'(last_seen), 64'(1));
    @(negedge clk);
    check("busy_in_drain", 64'(busy), 64'(1));
    @(negedge clk);
    check("busy_after_drain", 64'(busy), 64'(0));
    wait_done("frame1_done");
    check("frame1_count", 64'(xfer_cnt), 64'(FRAME));
    check("frame1_go", 64'(go_cnt), 64'(1));
    // 4 ARM cycles + 1 WAIT cycle + 2 cycles issue-to-valid latency
    check("first_latency", 64'(first_xfer_cyc - acc_cyc), 64'(7));
    check("throughput", 64'(last_xfer_cyc - first_xfer_cyc), 64'(FRAME - 1));

    // Random backpressure, ch_done dropped during READ
    ch_done = '0;
    new_frame(1'b1);
    ready_mode = 1;
    pulse_start();
    repeat ($urandom_range(5, 30)) @(posedge clk);
    #1 ch_done = '1;
    wait_xfers("frame2_reach200", 200);
    ch_done = 4'b0010;
    wait_done("frame2_done");
    check("frame2_count", 64'(xfer_cnt), 64'(FRAME));
    check("frame2_go", 64'(go_cnt), 64'(1));
    ready_mode = 0;

    // Timeout with one channel never done
    ch_done = 4'b0111;
    new_frame(1'b0);
    pulse_start();
    n = 0;
    while (!timeout_err && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    // 4 ARM cycles then TIMEOUT WAIT cycles
    check("timeout_cycles", 64'(n), 64'(4 + TOUT));
    check("timeout_idle", 64'(busy), 64'(0));
    repeat (20) @(posedge clk);
    #1;
    check("timeout_sticky", 64'(timeout_err), 64'(1));
    check("timeout_no_data", 64'(xfer_cnt), 64'(0));
    new_frame(1'b1);
    pulse_start();
    check("start_clears_err", 64'(timeout_err), 64'(0));
    repeat (5) @(posedge clk);
    #1 ch_done = '1;
    wait_done("frame3_done");
    check("frame3_count", 64'(xfer_cnt), 64'(FRAME));

    // Reset in the middle of a frame, then a clean frame
    new_frame(1'b1);
    pulse_start();
    wait_xfers("frame4_reach1500", 1500);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("no_xfer_after_reset", 64'(out_if.out_valid), 64'(0));
    new_frame(1'b1);
    pulse_start();
    wait_done("frame5_done");
    check("frame5_count", 64'(xfer_cnt), 64'(FRAME));
    check("frame5_go", 64'(go_cnt), 64'(1));

    // start pulsed while reading is ignored
    new_frame(1'b1);
    pulse_start();
    wait_xfers("frame6_reach100", 100);
    pulse_start();
    wait_done("frame6_done");
    check("frame6_count", 64'(xfer_cnt), 64'(FRAME));
    check("frame6_go", 64'(go_cnt), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    check("frame6_stays_idle", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_readout_sched.md
FFT_READOUT_SCHED -- requirements
Module: fft_readout_sched

Interface
REQ-001 Parameter NCH, default 4: number of FFT channel wrappers sequenced.
REQ-002 Parameter NPTS, default 1024: bins per channel; address width AW = 10.
REQ-003 Parameter DW, default 28: bin width, {real[13:0], imag[13:0]}.
REQ-004 Parameter TIMEOUT, default 65535: maximum WAIT cycles before error.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to process one frame.
REQ-008 ch_done  in  NCH  per-channel level: that channel's FFT RAM holds a complete result.
REQ-009 go  out  1  one-cycle rearm pulse to all channel wrappers.
REQ-010 rd_addr_fft  out  AW  shared read address to all channel FFT RAMs.
REQ-011 ram_q  in  NCH*DW  concatenated RAM outputs; channel k at bits [k*DW +: DW]; read latency exactly 1 cycle.
REQ-012 out_data  out  DW  bin value presented downstream.
REQ-013 out_ch  out  2  channel index of out_data.
REQ-014 out_bin  out  AW  bin index of out_data.
REQ-015 out_last  out  1  high with the final bin of the final channel.
REQ-016 out_valid  out  1 / out_ready  in  1  valid/ready handshake; a transfer occurs when both are high on a clk edge.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 timeout_err  out  1  sticky error flag; cleared only by reset or by an accepted start.

Function
REQ-019 FSM states: IDLE, ARM, WAIT, READ, DRAIN.
REQ-020 IDLE: start=1 -> ARM; start is ignored in all other states.
REQ-021 ARM: go=1 on the first ARM cycle only; ARM lasts 4 cycles to cover the wrapper's 2-FF go synchronizer; then -> WAIT.
REQ-022 WAIT: ch_done equal to all ones -> READ with channel 0, address 0; the wait counter increments each cycle.
REQ-023 WAIT counter reaches TIMEOUT -> timeout_err=1, -> IDLE, no output data.
REQ-024 READ: read order is channel-major (ch 0 bins 0..NPTS-1, then ch 1, ...); rd_addr_fft = bin of the issued read.
REQ-025 Output buffer is a 2-entry FIFO of {data, ch, bin, last}; a read issues only when occupancy + in-flight reads < 2.
REQ-026 Data returned one cycle after issue is selected from ram_q by the channel registered at issue and written to the FIFO.
REQ-027 out_valid = FIFO not empty; the outputs show the FIFO head; the head pops on transfer.
REQ-028 Sustained throughput is 1 bin/cycle while out_ready=1; latency from first issue to first out_valid is 2 cycles.
REQ-029 Boundary: bin NPTS-1 wraps to 0 and increments the channel; the issue of ch NCH-1, bin NPTS-1 -> DRAIN.
REQ-030 DRAIN: issue nothing; FIFO empty and no read in flight -> IDLE.
REQ-031 Simultaneous FIFO push and pop leave occupancy unchanged; the FIFO never overflows or underflows.
REQ-032 out_valid, once high, holds, and out_data/out_ch/out_bin/out_last stay stable until the transfer.
REQ-033 ch_done dropping during READ/DRAIN is ignored; the frame completes.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE; go, out_valid, out_last, busy and timeout_err = 0; rd_addr_fft, out_data, out_ch and out_bin = 0; FIFO and counters are cleared.
REQ-035 Reset mid-frame discards all buffered and in-flight data; no transfer occurs on the first edge after deassertion.

Verification
REQ-036 start pulse, ch_done=4'b1111 from cycle 5, out_ready=1 -> go is high for exactly 1 cycle; 4096 transfers in order; out_last only on ch 3, bin 1023; busy is low 1 cycle after DRAIN empties.
REQ-037 out_ready toggling 1,0,0,1 pseudo-randomly -> no lost or duplicated bin; out_data matches a RAM model at the address and channel in the output tags; payload stable while stalled.
REQ-038 ch_done=4'b0111 held with TIMEOUT=100 -> timeout_err=1 at WAIT cycle 100; no out_valid; next start clears timeout_err.
REQ-039 rst_n asserted at transfer 1500 -> all outputs 0 immediately; a new start then gives a clean full frame from ch 0, bin 0.
REQ-040 start pulsed during READ -> ignored; exactly 4096 transfers and a single go pulse.
